// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small byte FIFO fed by a valid/ready
// handshake, drained by a START/DATA/STOP serialiser with a registered TX line.
module uart_tx_buf #(
    parameter int FREQ  = 50_000_000,
    parameter int RATE  = 2_000_000,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 i_data,
    input  logic                       i_vld,
    output logic                       o_rdy,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int DIV = FREQ / RATE;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          line_active;
    logic          push;
    logic          pop;
    logic          bit_end;

    // A full FIFO refuses writes even when a pop happens on the same edge.
    assign o_rdy   = (count != FULL);
    assign push    = i_vld && o_rdy;
    assign bit_end = (div_cnt == DIV_LAST);
    assign o_count = count;
    // line_active trails the state by one cycle, matching the registered TX
    // line, so busy covers the full stop bit as seen on the wire.
    assign o_busy  = (state != IDLE) || line_active || (count != '0);

    // Next-state logic; pops happen from IDLE or on the last stop-bit cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (count != '0) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bit-period divider, restarted at every bit boundary so frames never drift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        div_cnt <= '0;
        else if (state == IDLE || bit_end) div_cnt <= '0;
        else                            div_cnt <= div_cnt + 1'b1;
    end

    // Data bit index, only advancing while shifting data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           bit_cnt <= '0;
        else if (state != DATA)            bit_cnt <= '0;
        else if (bit_end)                  bit_cnt <= bit_cnt + 1'b1;
    end

    // Shift register: loaded on pop, shifted right after each data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           shift <= '0;
        else if (pop)                      shift <= mem[rd_ptr];
        else if (state == DATA && bit_end) shift <= shift >> 1;
    end

    // Registered TX line driven from the current state and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tx        <= 1'b1;
            line_active <= 1'b0;
        end else begin
            line_active <= (state != IDLE);
            case (state)
                START:   o_tx <= 1'b0;
                DATA:    o_tx <= shift[0];
                default: o_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: a line decoder turns o_tx back into
// bytes and start times, which are compared with the bytes the handshake accepted.
module tb_uart_tx_buf;

    localparam int FREQ  = 50_000_000;
    localparam int RATE  = 2_000_000;
    localparam int DEPTH = 8;
    localparam int DIV   = FREQ / RATE;
    localparam int FRAME = 10 * DIV;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [7:0]    i_data;
    logic          i_vld;
    logic          o_rdy;
    logic          o_tx;
    logic          o_busy;
    logic [CW-1:0] o_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];
    bit         line_ok_q[$];
    int         line_start_q[$];

    bit         mon_active = 0;
    int         mon_pos;
    int         mon_start;
    bit         mon_ok;
    logic       mon_cur;
    logic [7:0] mon_byte;

    uart_tx_buf #(.FREQ(FREQ), .RATE(RATE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_vld(i_vld),
        .o_rdy(o_rdy), .o_tx(o_tx), .o_busy(o_busy), .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to timestamp stimulus and line events.
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: every bit must hold one level for DIV cycles; start=0, stop=1.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (o_tx === 1'b0) begin
                mon_active = 1;
                mon_pos    = 0;
                mon_start  = cyc;
                mon_ok     = 1;
                mon_cur    = 1'b0;
                mon_byte   = '0;
            end
        end else begin
            mon_pos++;
            if (mon_pos % DIV == 0) begin
                mon_cur = o_tx;
                if (mon_pos / DIV >= 1 && mon_pos / DIV <= 8) mon_byte[mon_pos/DIV-1] = o_tx;
                if (mon_pos / DIV == 9 && o_tx !== 1'b1) mon_ok = 0;
            end else if (o_tx !== mon_cur) begin
                mon_ok = 0;
            end
            if (mon_pos == FRAME - 1) begin
                line_q.push_back(mon_byte);
                line_ok_q.push_back(mon_ok);
                line_start_q.push_back(mon_start);
                mon_active = 0;
            end
        end
    end

    task automatic drive_cycle(input logic vld, input logic [7:0] d, output bit acc);
        i_vld  = vld;
        i_data = d;
        acc    = vld && (o_rdy === 1'b1);
        if (acc) exp_q.push_back(d);
        @(negedge clk);
        i_vld  = 1'b0;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, output bit timed_out);
        int budget = n * FRAME + 4 * FRAME;
        while (line_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        timed_out = (line_q.size() < n);
    endtask

    task automatic pop_frame(output logic [7:0] got, output logic [7:0] want,
                             output bit ok, output int st);
        got  = line_q.pop_front();
        ok   = line_ok_q.pop_front();
        st   = line_start_q.pop_front();
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_vld = 1'b0; i_data = '0;
        #1;
        vectors++; if (o_tx !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b want 1", o_tx); end
        vectors++; if (o_count !== 0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", o_count); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (o_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b want 1", o_rdy); end
        vectors++; if (o_tx !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_tx: got %b want 1", o_tx); end
    endtask

    task automatic test_single();
        bit acc, to, ok;
        int n, st;
        logic [7:0] got, want;
        drive_cycle(1'b1, 8'hA5, acc);
        n = cyc;
        vectors++; if (!acc) begin miscompares++; $display("[TB] FAIL single_accept: got 0 want 1"); end
        vectors++; if (o_count !== 1) begin miscompares++; $display("[TB] FAIL single_count1: got %0d want 1", o_count); end
        @(negedge clk);
        vectors++; if (o_count !== 0) begin miscompares++; $display("[TB] FAIL single_count0: got %0d want 0", o_count); end
        vectors++; if (o_tx !== 1'b1) begin miscompares++; $display("[TB] FAIL single_tx_n1: got %b want 1", o_tx); end
        @(negedge clk);
        vectors++; if (o_tx !== 1'b0) begin miscompares++; $display("[TB] FAIL single_tx_n2: got %b want 0", o_tx); end
        wait_until(n + FRAME);
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_stop: got %b want 1", o_busy); end
        wait_until(n + 2 + FRAME);
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_end: got %b want 0", o_busy); end
        wait_frames(1, to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL single_timeout: got %0d frames want 1", line_q.size()); end
        if (!to) begin
            pop_frame(got, want, ok, st);
            vectors++; if (got !== want) begin miscompares++; $display("[TB] FAIL single_byte: got %h want %h", got, want); end
            vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL single_framing: got 0 want 1"); end
            vectors++; if (st !== n + 2) begin miscompares++; $display("[TB] FAIL single_latency: got %0d want %0d", st - n, 2); end
        end
    endtask

    task automatic test_full();
        bit acc, to, ok;
        int accepted = 0, st;
        logic [7:0] got, want;
        drive_cycle(1'b1, 8'hEE, acc);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 8'(i), acc);
            if (acc) accepted++;
        end
        vectors++; if (accepted !== DEPTH) begin miscompares++; $display("[TB] FAIL full_accepted: got %0d want %0d", accepted, DEPTH); end
        vectors++; if (o_count !== DEPTH) begin miscompares++; $display("[TB] FAIL full_count: got %0d want %0d", o_count, DEPTH); end
        vectors++; if (o_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_rdy: got %b want 0", o_rdy); end
        wait_frames(DEPTH + 1, to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL full_timeout: got %0d frames want %0d", line_q.size(), DEPTH + 1); end
        while (line_q.size() > 0) begin
            pop_frame(got, want, ok, st);
            vectors++; if (got !== want || !ok) begin miscompares++; $display("[TB] FAIL full_byte: got %h ok=%b want %h", got, ok, want); end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, to, ok;
        int st0, st1;
        logic [7:0] got, want;
        drive_cycle(1'b1, 8'h55, acc);
        drive_cycle(1'b1, 8'hFF, acc);
        wait_frames(2, to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL b2b_timeout: got %0d frames want 2", line_q.size()); end
        if (!to) begin
            pop_frame(got, want, ok, st0);
            vectors++; if (got !== want || !ok) begin miscompares++; $display("[TB] FAIL b2b_first: got %h want %h", got, want); end
            pop_frame(got, want, ok, st1);
            vectors++; if (got !== want || !ok) begin miscompares++; $display("[TB] FAIL b2b_second: got %h want %h", got, want); end
            vectors++; if (st1 - st0 !== FRAME) begin miscompares++; $display("[TB] FAIL b2b_gap: got %0d want %0d", st1 - st0, FRAME); end
        end
    endtask

    task automatic test_push_pop();
        bit acc, to, ok;
        int n, st, prev;
        logic [7:0] got, want;
        drive_cycle(1'b1, 8'($urandom), acc);
        n = cyc;
        repeat (3) drive_cycle(1'b1, 8'($urandom), acc);
        wait_until(n + FRAME);
        vectors++; if (o_count !== 3) begin miscompares++; $display("[TB] FAIL pp_count_before: got %0d want 3", o_count); end
        drive_cycle(1'b1, 8'($urandom), acc);
        vectors++; if (o_count !== 3) begin miscompares++; $display("[TB] FAIL pp_count_after: got %0d want 3", o_count); end
        vectors++; if (o_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL pp_rdy: got %b want 1", o_rdy); end
        wait_frames(5, to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL pp_timeout: got %0d frames want 5", line_q.size()); end
        prev = -1;
        while (line_q.size() > 0) begin
            pop_frame(got, want, ok, st);
            vectors++; if (got !== want || !ok || (prev >= 0 && st - prev !== FRAME)) begin
                miscompares++; $display("[TB] FAIL pp_frame: got %h gap %0d want %h gap %0d", got, st - prev, want, FRAME);
            end
            prev = st;
        end
    endtask

    task automatic test_reset_mid();
        bit acc, to, ok;
        int n, st, lows = 0;
        logic [7:0] got, want;
        drive_cycle(1'b1, 8'h3C, acc);
        n = cyc;
        drive_cycle(1'b1, 8'($urandom), acc);
        drive_cycle(1'b1, 8'($urandom), acc);
        wait_until(n + 2 + 5 * DIV + DIV / 2);
        rst = 1'b1;
        exp_q.delete();
        #1;
        vectors++; if (o_tx !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_tx: got %b want 1", o_tx); end
        vectors++; if (o_count !== 0) begin miscompares++; $display("[TB] FAIL rstmid_count: got %0d want 0", o_count); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b want 0", o_busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (o_tx !== 1'b1) lows++;
        end
        vectors++; if (lows !== 0 || line_q.size() !== 0) begin
            miscompares++; $display("[TB] FAIL rstmid_idle: got %0d low cycles %0d frames want 0 0", lows, line_q.size());
        end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy_after: got %b want 0", o_busy); end
        drive_cycle(1'b1, 8'($urandom), acc);
        wait_frames(1, to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL rstmid_timeout: got %0d frames want 1", line_q.size()); end
        if (!to) begin
            pop_frame(got, want, ok, st);
            vectors++; if (got !== want || !ok) begin miscompares++; $display("[TB] FAIL rstmid_recover: got %h want %h", got, want); end
        end
    endtask

    task automatic test_random();
        bit acc, to, ok;
        int st, sent = 0, gap;
        logic [7:0] got, want;
        while (sent < 16) begin
            gap = $urandom_range(0, 3);
            repeat (gap) drive_cycle(1'b0, 8'($urandom), acc);
            drive_cycle(1'b1, 8'($urandom), acc);
            if (acc) sent++;
        end
        wait_frames(exp_q.size(), to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL rand_timeout: got %0d frames want %0d", line_q.size(), exp_q.size()); end
        while (line_q.size() > 0) begin
            pop_frame(got, want, ok, st);
            vectors++; if (got !== want || !ok) begin miscompares++; $display("[TB] FAIL rand_byte: got %h ok=%b want %h", got, ok, want); end
        end
    endtask

    task automatic test_loopback();
        bit acc, to, ok;
        int b = 0, budget = 256 * FRAME + 100, st, prev = -1;
        logic [7:0] got, want;
        while (b < 256 && budget > 0) begin
            drive_cycle(1'b1, 8'(b), acc);
            if (acc) b++;
            budget--;
        end
        vectors++; if (b !== 256) begin miscompares++; $display("[TB] FAIL loop_accept: got %0d want 256", b); end
        wait_frames(256, to);
        vectors++; if (to) begin miscompares++; $display("[TB] FAIL loop_timeout: got %0d frames want 256", line_q.size()); end
        for (int i = 0; i < 256 && line_q.size() > 0; i++) begin
            pop_frame(got, want, ok, st);
            vectors++; if (got !== want || got !== 8'(i) || !ok) begin
                miscompares++; $display("[TB] FAIL loop_byte%0d: got %h ok=%b want %h", i, got, ok, 8'(i));
            end
            vectors++; if (prev >= 0 && st - prev !== FRAME) begin
                miscompares++; $display("[TB] FAIL loop_gap%0d: got %0d want %0d", i, st - prev, FRAME);
            end
            prev = st;
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        $display("[TB] uart_tx_buf bench, DIV=%0d DEPTH=%0d", DIV, DEPTH);
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
